// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, address width helper, port-slice macro.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// RF_SLICE(vec, k, w) selects field k of width w from a flat packed port vector.
`ifndef RF_PKG_SV
`define RF_PKG_SV
`define RF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package rf_pkg;
   localparam int RF_XLEN_DEF  = 32;
   localparam int RF_NREGS_DEF = 32;
   localparam int RF_NRD_DEF   = 2;
   localparam int RF_NWR_DEF   = 2;

   // Address width for a register file of nregs entries (nregs is a power of 2, >= 2).
   function automatic int rf_aw(input int nregs);
      return $clog2(nregs);
   endfunction
endpackage
`endif

// File: rtl/register_file_mp_if.sv
// Bundle of register-file access signals between issue stage (master) and register file (slave).
// Latency: n/a (wiring only); read data/busy are combinational, wr_collision is registered.
// Backpressure: none; issue stalls itself on rs_busy.
//
// Signals: wr_en/wr_addr/wr_data (NWR write-back ports), rs_addr/rs_data/rs_busy (NRD read ports),
//          iss_valid/iss_addr (mark destination busy), flush (clear all busy), wr_collision.
interface register_file_mp_if
   import rf_pkg::*;
#(
   parameter int XLEN  = RF_XLEN_DEF,
   parameter int NREGS = RF_NREGS_DEF,
   parameter int NRD   = RF_NRD_DEF,
   parameter int NWR   = RF_NWR_DEF
) ();
   localparam int AW = rf_aw(NREGS);

   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NRD*AW-1:0]   rs_addr;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic                iss_valid;
   logic [AW-1:0]       iss_addr;
   logic                flush;
   logic                wr_collision;

   modport master (
      output wr_en, wr_addr, wr_data, rs_addr, iss_valid, iss_addr, flush,
      input  rs_data, rs_busy, wr_collision
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rs_addr, iss_valid, iss_addr, flush,
      output rs_data, rs_busy, wr_collision
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, all cleared on flush.
// Latency: busy updates at the clock edge; the same-cycle issue is visible next cycle.
// Backpressure: none; consumers read o_busy and stall themselves.
//
// Ports: i_clk, i_rst_n (sync, active low), i_iss_valid/i_iss_addr, i_wr_en/i_wr_addr (flat NWR vector),
//        i_flush, o_busy (one bit per register).
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS    = RF_NREGS_DEF,
   parameter int NWR      = RF_NWR_DEF,
   parameter int AW       = rf_aw(NREGS),
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_iss_valid,
   input  logic [AW-1:0]     i_iss_addr,
   input  logic [NWR-1:0]    i_wr_en,
   input  logic [NWR*AW-1:0] i_wr_addr,
   input  logic              i_flush,
   output logic [NREGS-1:0]  o_busy
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Priority per register: flush, then issue (a newer op owns the register even if an older
   // op writes back this cycle), then write-back clear, then hold.
   always_comb begin
      logic w_clr;
      w_busy_nxt = r_busy;
      w_clr      = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         w_clr = 1'b0;
         for (int k = 0; k < NWR; k++) begin
            if (i_wr_en[k] && (`RF_SLICE(i_wr_addr, k, AW) == AW'(r))) begin
               w_clr = 1'b1;
            end
         end
         if (i_flush) begin
            w_busy_nxt[r] = 1'b0;
         end else if (i_iss_valid && (i_iss_addr == AW'(r))) begin
            w_busy_nxt[r] = 1'b1;
         end else if (w_clr) begin
            w_busy_nxt[r] = 1'b0;
         end
         // Register 0 is hardwired: it can never be pending.
         if (ZERO_REG && (r == 0)) begin
            w_busy_nxt[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and write collision flag.
// Latency: reads are combinational (0 cycles, bypassing same-cycle writes); writes land at the edge.
// Backpressure: none; issue stalls on rs_busy, colliding writes resolve to the highest port.
//
// Ports: clk, rst_n (sync, active low), bus (register_file_mp_if.slave: write ports, read ports,
//        issue/flush for the scoreboard, registered wr_collision pulse).
module register_file_mp
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN_DEF,
   parameter int NREGS    = RF_NREGS_DEF,
   parameter int NRD      = RF_NRD_DEF,
   parameter int NWR      = RF_NWR_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   register_file_mp_if.slave  bus
);
   localparam int AW = rf_aw(NREGS);

   logic [XLEN-1:0]     r_regs [NREGS];
   logic                r_wr_collision;

   logic [NWR-1:0]      w_wr_ok;
   logic                w_collision;
   logic [NREGS-1:0]    w_busy;
   logic [NRD*XLEN-1:0] w_rs_data;
   logic [NRD-1:0]      w_rs_busy;

   // A write port is effective when enabled and not aimed at the hardwired zero register.
   always_comb begin
      w_wr_ok = '0;
      for (int k = 0; k < NWR; k++) begin
         w_wr_ok[k] = bus.wr_en[k] &&
                      !(ZERO_REG && (`RF_SLICE(bus.wr_addr, k, AW) == AW'(0)));
      end
   end

   // Any pair of effective ports on the same address is a collision; dropped r0 writes never count.
   always_comb begin
      w_collision = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         for (int k = j + 1; k < NWR; k++) begin
            if (w_wr_ok[j] && w_wr_ok[k] &&
                (`RF_SLICE(bus.wr_addr, j, AW) == `RF_SLICE(bus.wr_addr, k, AW))) begin
               w_collision = 1'b1;
            end
         end
      end
   end

   // Ports are applied in ascending order so the highest-numbered port's value is the one kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_wr_collision <= 1'b0;
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (w_wr_ok[k]) begin
               r_regs[`RF_SLICE(bus.wr_addr, k, AW)] <= `RF_SLICE(bus.wr_data, k, XLEN);
            end
         end
         r_wr_collision <= w_collision;
      end
   end

   // Scoreboard sees the masked write enables so r0 write-backs are inert there too.
   rf_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_iss_valid (bus.iss_valid),
      .i_iss_addr  (bus.iss_addr),
      .i_wr_en     (w_wr_ok),
      .i_wr_addr   (bus.wr_addr),
      .i_flush     (bus.flush),
      .o_busy      (w_busy)
   );

   // Read path: stored value, overridden by the highest matching write port this cycle.
   // A matching write-back also hides the busy bit it is about to clear.
   always_comb begin
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_rd;
      logic            w_hit;
      w_rs_data = '0;
      w_rs_busy = '0;
      w_ra      = '0;
      w_rd      = '0;
      w_hit     = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         w_ra  = `RF_SLICE(bus.rs_addr, i, AW);
         w_rd  = r_regs[w_ra];
         w_hit = 1'b0;
         for (int k = 0; k < NWR; k++) begin
            if (w_wr_ok[k] && (`RF_SLICE(bus.wr_addr, k, AW) == w_ra)) begin
               w_rd  = `RF_SLICE(bus.wr_data, k, XLEN);
               w_hit = 1'b1;
            end
         end
         if (ZERO_REG && (w_ra == AW'(0))) begin
            w_rd = '0;
         end
         `RF_SLICE(w_rs_data, i, XLEN) = w_rd;
         w_rs_busy[i] = w_busy[w_ra] & ~w_hit;
      end
   end

   assign bus.rs_data      = w_rs_data;
   assign bus.rs_busy      = w_rs_busy;
   assign bus.wr_collision = r_wr_collision;
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: reset sweep, directed vector table, randomized model check.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_register_file_mp;
   import rf_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

   register_file_mp #(
      .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          rst;
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      bit          iss;
      logic [4:0]  ia;
      bit          fl;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_busy;
      bit          e_coll;
   } vec_t;

   vec_t vt[$];

   task automatic add(input bit rst, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input bit iss, input logic [4:0] ia, input bit fl,
                      input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                      input logic [1:0] e_busy, input bit e_coll);
      vec_t v;
      v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ia = ia; v.fl = fl;
      v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_coll = e_coll;
      vt.push_back(v);
   endtask

   task automatic drive(input bit rst, input logic [1:0] we,
                        input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input bit iss, input logic [4:0] ia, input bit fl);
      rst_n         = ~rst;
      bus.wr_en     = we;
      bus.wr_addr   = {wa1, wa0};
      bus.wr_data   = {wd1, wd0};
      bus.rs_addr   = {ra1, ra0};
      bus.iss_valid = iss;
      bus.iss_addr  = ia;
      bus.flush     = fl;
   endtask

   // Reference model: architectural register contents, pending flags and the collision flag.
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   bit          m_coll;

   // Expected read for one port given the current write ports.
   task automatic model_read(input logic [4:0] a, input logic [1:0] we,
                             input logic [4:0] wa [2], input logic [31:0] wd [2],
                             output logic [31:0] d, output bit b);
      bit hit;
      d   = m_regs[a];
      hit = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (we[k] && wa[k] == a && a != 0) begin
            d   = wd[k];
            hit = 1'b1;
         end
      end
      if (a == 0) d = 0;
      b = (a != 0) && m_busy[a] && !hit;
   endtask

   // Advance the model across one clock edge.
   task automatic model_edge(input bit rst, input logic [1:0] we,
                             input logic [4:0] wa [2], input logic [31:0] wd [2],
                             input bit iss, input logic [4:0] ia, input bit fl);
      bit written [32];
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_busy[r] = 0;
         end
         m_coll = 0;
         return;
      end
      for (int r = 0; r < 32; r++) written[r] = 0;
      m_coll = we[0] && we[1] && wa[0] == wa[1] && wa[0] != 0;
      for (int k = 0; k < 2; k++) begin
         if (we[k] && wa[k] != 0) begin
            m_regs[wa[k]] = wd[k];
            written[wa[k]] = 1;
         end
      end
      for (int r = 1; r < 32; r++) begin
         if (fl) m_busy[r] = 0;
         else if (iss && ia == r) m_busy[r] = 1;
         else if (written[r]) m_busy[r] = 0;
      end
   endtask

   initial begin
      logic [31:0] e_d0, e_d1;
      bit          e_b0, e_b1;
      logic [4:0]  rwa [2];
      logic [31:0] rwd [2];
      logic [1:0]  rwe;
      logic [4:0]  rra0, rra1, ria;
      bit          riss, rfl, rrst;

      // Directed sequence; outputs are sampled before the edge of the same row.
      //   rst we     wa0 wd0           wa1 wd1           ra0 ra1 iss ia  fl  rd0           rd1           busy   coll
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        0,  5,  0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
      add(0, 2'b01, 1,  32'h12345678, 0,  32'h0,        1,  2,  0,  0,  0,  32'h12345678, 32'h0,        2'b00, 0);
      add(0, 2'b10, 0,  32'h0,        2,  32'h87654321, 1,  2,  0,  0,  0,  32'h12345678, 32'h87654321, 2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        1,  2,  0,  0,  0,  32'h12345678, 32'h87654321, 2'b00, 0);
      add(0, 2'b01, 5,  32'hCAFEF00D, 0,  32'h0,        0,  5,  0,  0,  0,  32'h0,        32'hCAFEF00D, 2'b00, 0);
      add(0, 2'b11, 3,  32'h11111111, 3,  32'h22222222, 3,  5,  0,  0,  0,  32'h22222222, 32'hCAFEF00D, 2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        3,  0,  0,  0,  0,  32'h22222222, 32'h0,        2'b00, 1);
      add(0, 2'b11, 0,  32'hDEADBEEF, 0,  32'h12121212, 0,  3,  0,  0,  0,  32'h0,        32'h22222222, 2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        0,  3,  0,  0,  0,  32'h0,        32'h22222222, 2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  7,  1,  7,  0,  32'h0,        32'h0,        2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  3,  0,  0,  0,  32'h0,        32'h22222222, 2'b01, 0);
      add(0, 2'b01, 7,  32'h77,       0,  32'h0,        7,  7,  0,  0,  0,  32'h77,       32'h77,       2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  7,  0,  0,  0,  32'h77,       32'h77,       2'b00, 0);
      add(0, 2'b10, 0,  32'h0,        7,  32'h78,       7,  3,  1,  7,  0,  32'h78,       32'h22222222, 2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  7,  0,  0,  0,  32'h78,       32'h78,       2'b11, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  9,  1,  9,  1,  32'h78,       32'h0,        2'b01, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        7,  9,  1,  10, 0,  32'h78,       32'h0,        2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        10, 4,  1,  4,  0,  32'h0,        32'h0,        2'b01, 0);
      add(1, 2'b11, 4,  32'hDEADBEEF, 4,  32'hDEADBEEF, 4,  10, 1,  8,  0,  32'hDEADBEEF, 32'h0,        2'b10, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        4,  10, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
      add(0, 2'b00, 0,  32'h0,        0,  32'h0,        3,  8,  0,  0,  0,  32'h0,        32'h0,        2'b00, 0);

      // Reset, then sweep every register on both ports.
      drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_coll", {31'b0, bus.wr_collision}, 32'h0);
      for (int r = 0; r < 32; r++) begin
         bus.rs_addr = {5'(31 - r), 5'(r)};
         #1;
         check($sformatf("reset_rd0_r%0d", r), bus.rs_data[31:0], 32'h0);
         check($sformatf("reset_busy_r%0d", r), {30'b0, bus.rs_busy}, 32'h0);
      end
      @(posedge clk);
      #1;

      foreach (vt[n]) begin
         drive(vt[n].rst, vt[n].we, vt[n].wa0, vt[n].wd0, vt[n].wa1, vt[n].wd1,
               vt[n].ra0, vt[n].ra1, vt[n].iss, vt[n].ia, vt[n].fl);
         @(negedge clk);
         check($sformatf("vec%0d_rd0", n), bus.rs_data[31:0], vt[n].e_rd0);
         check($sformatf("vec%0d_rd1", n), bus.rs_data[63:32], vt[n].e_rd1);
         check($sformatf("vec%0d_busy", n), {30'b0, bus.rs_busy}, {30'b0, vt[n].e_busy});
         check($sformatf("vec%0d_coll", n), {31'b0, bus.wr_collision}, {31'b0, vt[n].e_coll});
         @(posedge clk);
         #1;
      end

      // The directed table ends with everything back at reset values.
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 0;
         m_busy[r] = 0;
      end
      m_coll = 0;

      // Randomized traffic on a narrow address window to provoke bypasses and collisions.
      for (int c = 0; c < 400; c++) begin
         rwe    = 2'($urandom_range(0, 3));
         rwa[0] = 5'($urandom_range(0, 7));
         rwa[1] = 5'($urandom_range(0, 7));
         rwd[0] = $urandom;
         rwd[1] = $urandom;
         rra0   = 5'($urandom_range(0, 7));
         rra1   = 5'($urandom_range(0, 7));
         riss   = ($urandom_range(0, 2) == 0);
         ria    = 5'($urandom_range(0, 7));
         rfl    = ($urandom_range(0, 15) == 0);
         rrst   = ($urandom_range(0, 63) == 0);
         drive(rrst, rwe, rwa[0], rwd[0], rwa[1], rwd[1], rra0, rra1, riss, ria, rfl);
         @(negedge clk);
         model_read(rra0, rwe, rwa, rwd, e_d0, e_b0);
         model_read(rra1, rwe, rwa, rwd, e_d1, e_b1);
         check($sformatf("rnd%0d_rd0", c), bus.rs_data[31:0], e_d0);
         check($sformatf("rnd%0d_rd1", c), bus.rs_data[63:32], e_d1);
         check($sformatf("rnd%0d_busy", c), {30'b0, bus.rs_busy}, {30'b0, e_b1, e_b0});
         check($sformatf("rnd%0d_coll", c), {31'b0, bus.wr_collision}, {31'b0, m_coll});
         model_edge(rrst, rwe, rwa, rwd, riss, ria, rfl);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
